// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM: 3-point majority sampler, LSB-first deserializer,
// parity and stop checks; drives the external edge/bit counter.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [3:0]            bit_cnt,
    output logic                  counter_en,
    output logic                  new_start,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  framing_error
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [3:0] LAST_IDX = 4'(DATA_WIDTH);
    localparam logic [3:0] PAR_IDX  = 4'(DATA_WIDTH + 1);

    state_t                  state, state_nx;
    logic [DATA_WIDTH-1:0]   sr, sr_nx;
    logic                    par_acc, par_acc_nx;
    logic                    par_err, par_err_nx;
    logic                    par_en_l, par_en_nx;
    logic                    par_typ_l, par_typ_nx;
    logic                    stop_done, stop_done_nx;
    logic                    ferr, ferr_nx;
    logic                    cen_nx, nst_nx, dv_nx, pe_nx, fe_nx;
    logic [DATA_WIDTH-1:0]   pdata_nx;

    logic [PRESCALE_W-1:0]   mid;
    logic                    smp_a, smp_b, smp_c;
    logic                    sampled_bit, at_eval, at_end;
    logic [3:0]              stop_idx;

    assign mid         = prescale >> 1;
    assign sampled_bit = (smp_a & smp_b) | (smp_a & smp_c) | (smp_b & smp_c);
    assign at_eval     = (edge_cnt == mid + PRESCALE_W'(2));
    assign at_end      = (edge_cnt == prescale);
    assign stop_idx    = PAR_IDX + {3'b000, par_en_l};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            smp_a <= 1'b0;
            smp_b <= 1'b0;
            smp_c <= 1'b0;
        end else begin
            if (edge_cnt == mid - PRESCALE_W'(1)) smp_a <= RX_IN;
            if (edge_cnt == mid)                  smp_b <= RX_IN;
            if (edge_cnt == mid + PRESCALE_W'(1)) smp_c <= RX_IN;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            sr            <= '0;
            par_acc       <= 1'b0;
            par_err       <= 1'b0;
            par_en_l      <= 1'b0;
            par_typ_l     <= 1'b0;
            stop_done     <= 1'b0;
            ferr          <= 1'b0;
            counter_en    <= 1'b0;
            new_start     <= 1'b0;
            P_DATA        <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state         <= state_nx;
            sr            <= sr_nx;
            par_acc       <= par_acc_nx;
            par_err       <= par_err_nx;
            par_en_l      <= par_en_nx;
            par_typ_l     <= par_typ_nx;
            stop_done     <= stop_done_nx;
            ferr          <= ferr_nx;
            counter_en    <= cen_nx;
            new_start     <= nst_nx;
            P_DATA        <= pdata_nx;
            data_valid    <= dv_nx;
            parity_error  <= pe_nx;
            framing_error <= fe_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        sr_nx        = sr;
        par_acc_nx   = par_acc;
        par_err_nx   = par_err;
        par_en_nx    = par_en_l;
        par_typ_nx   = par_typ_l;
        stop_done_nx = stop_done;
        ferr_nx      = ferr;
        cen_nx       = counter_en;
        nst_nx       = 1'b0;
        pdata_nx     = P_DATA;
        dv_nx        = 1'b0;
        pe_nx        = 1'b0;
        fe_nx        = 1'b0;

        case (state)
            IDLE: begin
                cen_nx = 1'b0;
                if (!RX_IN) begin
                    state_nx   = START;
                    cen_nx     = 1'b1;
                    par_en_nx  = PAR_EN;
                    par_typ_nx = PAR_TYP;
                end
            end
            START: begin
                // per-frame flags are cleared here so both entry paths share it
                par_acc_nx   = 1'b0;
                par_err_nx   = 1'b0;
                stop_done_nx = 1'b0;
                ferr_nx      = 1'b0;
                if (at_eval && bit_cnt == 4'd0) begin
                    if (sampled_bit) begin
                        state_nx = IDLE;
                        cen_nx   = 1'b0;
                    end
                end else if (bit_cnt == 4'd1) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                if (at_eval && bit_cnt >= 4'd1 && bit_cnt <= LAST_IDX) begin
                    sr_nx      = {sampled_bit, sr[DATA_WIDTH-1:1]};
                    par_acc_nx = par_acc ^ sampled_bit;
                end
                if (bit_cnt == PAR_IDX)
                    state_nx = par_en_l ? PARITY : STOP;
            end
            PARITY: begin
                if (at_eval && bit_cnt == PAR_IDX)
                    par_err_nx = sampled_bit ^ par_acc ^ par_typ_l;
                if (bit_cnt == stop_idx)
                    state_nx = STOP;
            end
            STOP: begin
                if (!stop_done) begin
                    if (at_eval && bit_cnt == stop_idx) begin
                        stop_done_nx = 1'b1;
                        fe_nx        = ~sampled_bit;
                        ferr_nx      = ~sampled_bit;
                        pe_nx        = par_en_l & par_err;
                        if (sampled_bit && !(par_en_l && par_err)) begin
                            pdata_nx = sr;
                            dv_nx    = 1'b1;
                        end
                    end
                end else if (ferr) begin
                    // a low stop bit may be a held break: leave only once the line is high
                    if (RX_IN) begin
                        state_nx = IDLE;
                        cen_nx   = 1'b0;
                    end
                end else if (!RX_IN) begin
                    state_nx   = START;
                    nst_nx     = 1'b1;
                    par_en_nx  = PAR_EN;
                    par_typ_nx = PAR_TYP;
                end else if (at_end) begin
                    state_nx = IDLE;
                    cen_nx   = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
                cen_nx   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm; includes a behavioural edge/bit counter.
module tb_uart_rx_fsm;

    localparam int DW = 8;
    localparam int PW = 5;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] prescale = PW'(8);
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [PW-1:0] edge_cnt;
    logic [3:0]    bit_cnt;
    logic          counter_en, new_start;
    logic [DW-1:0] P_DATA;
    logic          data_valid, parity_error, framing_error;

    always #5 CLK = ~CLK;

    uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .prescale(prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
        .counter_en(counter_en), .new_start(new_start), .P_DATA(P_DATA),
        .data_valid(data_valid), .parity_error(parity_error), .framing_error(framing_error)
    );

    // Counter: cleared while disabled, reloaded to position 1 of the start bit on new_start
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (new_start) begin
            edge_cnt <= PW'(1);
            bit_cnt  <= '0;
        end else if (!counter_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt == prescale) begin
            edge_cnt <= PW'(1);
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + PW'(1);
        end
    end

    int            n_dv, n_pe, n_fe, n_ns;
    logic [DW-1:0] got_q[$];

    always @(negedge CLK) begin
        if (RST) begin
            if (data_valid) begin
                n_dv++;
                got_q.push_back(P_DATA);
            end
            if (parity_error)  n_pe++;
            if (framing_error) n_fe++;
            if (new_start)     n_ns++;
        end
    end

    int n_vec, n_err;
    int b_dv, b_pe, b_fe, b_ns;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        b_dv = n_dv; b_pe = n_pe; b_fe = n_fe; b_ns = n_ns;
    endtask

    task automatic chk_counts(input string tag, input int edv, input int epe, input int efe, input int ens);
        chk({tag, "_dv"}, n_dv - b_dv, edv);
        chk({tag, "_pe"}, n_pe - b_pe, epe);
        chk({tag, "_fe"}, n_fe - b_fe, efe);
        chk({tag, "_ns"}, n_ns - b_ns, ens);
    endtask

    task automatic chk_word(input string tag, input logic [DW-1:0] exp);
        if (got_q.size() == 0) chk(tag, 32'hFFFF_FFFF, 32'(exp));
        else                   chk(tag, 32'(got_q.pop_front()), 32'(exp));
    endtask

    task automatic drive_bit(input logic v, input int len);
        RX_IN = v;
        repeat (len) @(negedge CLK);
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input bit with_par, input logic par_bit,
                              input logic stop_bit, input int stop_len, input bit flip);
        int ps;
        ps = int'(prescale);
        drive_bit(1'b0, ps);
        if (flip) begin
            PAR_EN  = ~PAR_EN;
            PAR_TYP = ~PAR_TYP;
        end
        for (int i = 0; i < DW; i++) drive_bit(d[i], ps);
        if (with_par) drive_bit(par_bit, ps);
        drive_bit(stop_bit, stop_len);
        RX_IN = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d6;
        d6 = 8'h5A;

        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_cen",    32'(counter_en), 32'h0);
        chk("rst_pdata",  32'(P_DATA), 32'h0);
        chk("rst_pulses", 32'({data_valid, parity_error, framing_error, new_start}), 32'h0);
        RST = 1'b1;
        idle(5);
        chk("idle_cen", 32'(counter_en), 32'h0);

        // 8x, no parity, 0xA5
        prescale = PW'(8); PAR_EN = 1'b0;
        snap();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 8, 1'b0);
        idle(20);
        chk_counts("t1", 1, 0, 0, 0);
        chk_word("t1_data", 8'hA5);
        chk("t1_cen_off", 32'(counter_en), 32'h0);

        // 16x, even parity, good then bad parity bit
        prescale = PW'(16); PAR_EN = 1'b1; PAR_TYP = 1'b0;
        snap();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16, 1'b0);
        idle(40);
        chk_counts("t2a", 1, 0, 0, 0);
        chk_word("t2a_data", 8'h3C);
        snap();
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 16, 1'b0);
        idle(40);
        chk_counts("t2b", 0, 1, 0, 0);
        chk("t2b_hold", 32'(P_DATA), 32'h3C);
        chk("t2b_q", got_q.size(), 0);

        // odd parity; PAR_EN/PAR_TYP flipped mid-frame must be ignored
        prescale = PW'(8); PAR_EN = 1'b1; PAR_TYP = 1'b1;
        snap();
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, 8, 1'b1);
        idle(20);
        PAR_EN = 1'b1; PAR_TYP = 1'b1;
        chk_counts("t2c", 1, 0, 0, 0);
        chk_word("t2c_data", 8'h07);

        // framing error
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
        snap();
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 8, 1'b0);
        idle(20);
        chk_counts("t3", 0, 0, 1, 0);
        chk("t3_hold", 32'(P_DATA), 32'h07);
        chk("t3_cen_off", 32'(counter_en), 32'h0);

        // start glitch, then a good frame
        snap();
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 3);
        chk("t4_cen_busy", 32'(counter_en), 32'h1);
        idle(20);
        chk_counts("t4g", 0, 0, 0, 0);
        chk("t4_cen_off", 32'(counter_en), 32'h0);
        snap();
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 8, 1'b0);
        idle(20);
        chk_counts("t4", 1, 0, 0, 0);
        chk_word("t4_data", 8'h0F);

        // back-to-back at 16x: second start edge after stop eval, before bit end
        prescale = PW'(16);
        snap();
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 13, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1, 16, 1'b0);
        idle(40);
        chk_counts("t5", 2, 0, 0, 1);
        chk_word("t5_data0", 8'h55);
        chk_word("t5_data1", 8'hAA);

        // async reset during data bit 4
        prescale = PW'(8);
        drive_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) drive_bit(d6[i], 8);
        drive_bit(d6[4], 3);
        chk("t6_cen_busy", 32'(counter_en), 32'h1);
        RST = 1'b0;
        #1;
        chk("t6_rst_cen",    32'(counter_en), 32'h0);
        chk("t6_rst_pdata",  32'(P_DATA), 32'h0);
        chk("t6_rst_pulses", 32'({data_valid, parity_error, framing_error, new_start}), 32'h0);
        @(negedge CLK);
        RX_IN = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        idle(10);
        snap();
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 8, 1'b0);
        idle(20);
        chk_counts("t6", 1, 0, 0, 0);
        chk_word("t6_data", 8'hC3);
        chk("t6_pdata", 32'(P_DATA), 32'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
